// File: rtl/mac_seq_ctrl.sv
// Job sequencer for the 8x8->16 MAC: accepts a dot-product command, streams operand
// pairs into the MAC, drains its pipeline and returns the accumulated sum.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a command; MAC disabled so its sum is held at 0
// RUN   | accepting operand pairs; zero operands are fed on bubbles
// DRAIN | MAC still enabled with zero operands until the last product lands
// DONE  | result presented; MAC disabled, which clears the sum for the next job
module mac_seq_ctrl #(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  input  logic             abort,
  output logic             mac_enable,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  input  logic [15:0]      mac_c,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             busy
);

  // Drain length covers operand reg + accumulate + the MAC output register.
  localparam int                 DRAIN_W    = $clog2(MAC_LAT + 2);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(MAC_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [LEN_W-1:0]   remaining;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               accept;

  always_comb begin
    cmd_ready  = (state == IDLE);
    op_ready   = (state == RUN) && !abort;
    accept     = op_valid && op_ready;
    mac_enable = (state == RUN) || (state == DRAIN);
    mac_a      = accept ? op_a : 8'd0;
    mac_b      = accept ? op_b : 8'd0;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      drain_cnt <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_len == '0) begin
              res_data  <= '0;
              res_valid <= 1'b1;
              state     <= DONE;
            end else begin
              remaining <= cmd_len;
              state     <= RUN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (accept) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              drain_cnt <= DRAIN_LOAD;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
            if (drain_cnt == DRAIN_W'(1)) begin
              res_data  <= mac_c;
              res_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (abort || res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: behavioural MAC model on the datapath side, directed jobs,
// and a result scoreboard checked by an independent monitor.
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_len;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        abort;
  logic        mac_enable;
  logic [7:0]  mac_a;
  logic [7:0]  mac_b;
  logic [15:0] mac_c;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  logic [7:0]  a_reg, b_reg;
  logic [15:0] sum;

  always #5 clk = ~clk;

  mac_seq_ctrl #(.LEN_W(8), .MAC_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .abort(abort),
    .mac_enable(mac_enable), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  // MAC: operand regs, accumulator cleared while disabled, registered output.
  always @(posedge clk) begin
    if (reset) begin
      a_reg <= '0; b_reg <= '0; sum <= '0; mac_c <= '0;
    end else begin
      a_reg <= mac_a;
      b_reg <= mac_b;
      if (mac_enable) sum <= sum + 16'(a_reg) * 16'(b_reg);
      else            sum <= '0;
      mac_c <= sum;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, expv);
  endtask

  // Monitor: every completed result handshake is compared against the scoreboard.
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(res_data), 32'hFFFF_FFFF);
      end else begin
        check("res_data", 32'(res_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] len, input bit has_exp, input logic [15:0] expv);
    int t = 0;
    if (has_exp) exp_q.push_back(expv);
    cmd_valid = 1'b1;
    cmd_len   = len;
    while (!cmd_ready && t < 50) begin tick(); t++; end
    if (t >= 50) check("cmd_ready_timeout", 32'(t), 0);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_op(input logic [7:0] a, input logic [7:0] b, input int gap);
    int t = 0;
    op_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      tick();
      check("bubble_mac_a", 32'(mac_a), 0);
      check("bubble_mac_b", 32'(mac_b), 0);
      check("bubble_mac_en", 32'(mac_enable), 1);
    end
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    #1;
    while (!op_ready && t < 50) begin tick(); t++; end
    if (t >= 50) check("op_ready_timeout", 32'(t), 0);
    tick();
    op_valid = 1'b0;
  endtask

  // Cycles from the last accept edge until res_valid is seen; DRAIN must keep the MAC enabled.
  task automatic wait_res(output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 20) begin
      tick();
      cyc++;
      if (!res_valid) check("drain_mac_en", 32'(mac_enable), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; op_valid = 1'b0;
    op_a = '0; op_b = '0; abort = 1'b0; res_ready = 1'b1;
    tick(); tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_op_ready", 32'(op_ready), 0);
    check("rst_mac_en", 32'(mac_enable), 0);
    reset = 1'b0;
    tick();

    // back-to-back 1*2+3*4+5*6
    send_cmd(8'd3, 1'b1, 16'd44);
    send_op(8'd1, 8'd2, 0);
    send_op(8'd3, 8'd4, 0);
    send_op(8'd5, 8'd6, 0);
    wait_res(lat);
    check("lat_b2b", 32'(lat), 3);
    check("done_mac_en", 32'(mac_enable), 0);
    tick();

    // same job with 2-cycle bubbles
    send_cmd(8'd3, 1'b1, 16'd44);
    send_op(8'd1, 8'd2, 2);
    send_op(8'd3, 8'd4, 2);
    send_op(8'd5, 8'd6, 2);
    wait_res(lat);
    check("lat_bubble", 32'(lat), 3);
    tick();

    // wrap: 2*65025 mod 2^16
    send_cmd(8'd2, 1'b1, 16'd64514);
    send_op(8'd255, 8'd255, 0);
    send_op(8'd255, 8'd255, 0);
    wait_res(lat);
    check("lat_wrap", 32'(lat), 3);
    tick();

    // zero-length job
    send_cmd(8'd0, 1'b1, 16'd0);
    check("len0_res_valid", 32'(res_valid), 1);
    check("len0_res_data", 32'(res_data), 0);
    check("len0_mac_en", 32'(mac_enable), 0);
    tick();
    check("len0_mac_en_after", 32'(mac_enable), 0);

    // result back-pressure, then back-to-back second job
    res_ready = 1'b0;
    send_cmd(8'd3, 1'b1, 16'd44);
    send_op(8'd1, 8'd2, 0);
    send_op(8'd3, 8'd4, 0);
    send_op(8'd5, 8'd6, 0);
    wait_res(lat);
    for (int i = 0; i < 5; i++) begin
      check("stall_res_valid", 32'(res_valid), 1);
      check("stall_res_data", 32'(res_data), 44);
      check("stall_cmd_ready", 32'(cmd_ready), 0);
      check("stall_mac_en", 32'(mac_enable), 0);
      tick();
    end
    res_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_len   = 8'd1;
    #1;
    check("handoff_cmd_ready", 32'(cmd_ready), 0);
    send_cmd(8'd1, 1'b1, 16'd56);
    send_op(8'd7, 8'd8, 0);
    wait_res(lat);
    check("lat_second", 32'(lat), 3);
    tick();

    // abort after two accepts; operand in the abort cycle must not be taken
    send_cmd(8'd4, 1'b0, 16'd0);
    send_op(8'd2, 8'd3, 0);
    send_op(8'd4, 8'd5, 0);
    op_valid = 1'b1; op_a = 8'd100; op_b = 8'd100; abort = 1'b1;
    #1;
    check("abort_op_ready", 32'(op_ready), 0);
    check("abort_mac_a", 32'(mac_a), 0);
    tick();
    abort = 1'b0; op_valid = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_res_valid", 32'(res_valid), 0);
    check("abort_cmd_ready", 32'(cmd_ready), 1);
    tick(); tick();
    check("abort_no_result", 32'(res_valid), 0);

    // abort in IDLE together with a command: command still accepted
    abort = 1'b1;
    send_cmd(8'd1, 1'b1, 16'd81);
    abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 1);
    send_op(8'd9, 8'd9, 0);
    wait_res(lat);
    check("lat_after_abort", 32'(lat), 3);
    tick();

    // reset mid-RUN
    send_cmd(8'd3, 1'b0, 16'd0);
    send_op(8'd1, 8'd1, 0);
    reset = 1'b1;
    tick();
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_res_valid", 32'(res_valid), 0);
    check("mid_rst_res_data", 32'(res_data), 0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 1);
    check("mid_rst_op_ready", 32'(op_ready), 0);
    check("mid_rst_mac_en", 32'(mac_enable), 0);
    reset = 1'b0;
    tick(); tick(); tick();

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
